// File: rtl/dds_key_ctrl_if.sv
// DDS configuration channel: registered wave/amp/frequency word with valid/ready handshake.
// The master holds cfg_vld and all payload fields stable until cfg_rdy is seen.
interface dds_key_ctrl_if;
  logic        cfg_vld;
  logic        cfg_rdy;
  logic [1:0]  wave_sel;
  logic [1:0]  amp_sel;
  logic [31:0] fword;

  modport master (
    output cfg_vld,
    output wave_sel,
    output amp_sel,
    output fword,
    input  cfg_rdy
  );

  modport slave (
    input  cfg_vld,
    input  wave_sel,
    input  amp_sel,
    input  fword,
    output cfg_rdy
  );
endinterface

// File: rtl/dds_key_ctrl.sv
// Key pulses -> staged DDS settings -> registered config; cfg_vld rises two edges after the key edge.
// While cfg_vld waits for cfg_rdy, further key changes are absorbed and reissued as one extra config.
module dds_key_ctrl #(
  parameter int unsigned FW_STEP   = 85899,
  parameter int unsigned FREQ_MIN  = 1,
  parameter int unsigned FREQ_MAX  = 100,
  parameter int unsigned FREQ_INIT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          key_wave,
  input  logic          key_up,
  input  logic          key_dn,
  input  logic          key_amp,
  dds_key_ctrl_if.master cfg
);

  localparam int unsigned      IDX_W      = $clog2(FREQ_MAX + 1);
  localparam logic [IDX_W-1:0] C_IDX_MIN  = IDX_W'(FREQ_MIN);
  localparam logic [IDX_W-1:0] C_IDX_MAX  = IDX_W'(FREQ_MAX);
  localparam logic [IDX_W-1:0] C_IDX_INIT = IDX_W'(FREQ_INIT);
  localparam logic [31:0]      C_STEP     = 32'(FW_STEP);
  localparam logic [31:0]      C_FW_INIT  = 32'(FREQ_INIT * FW_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_wave;
  logic [1:0]       r_amp;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       w_wave_nxt;
  logic [1:0]       w_amp_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_eff;
  logic             r_chg;
  logic             r_pend;
  logic             w_pend_nxt;
  logic             w_any_pend;
  logic [31:0]      w_prod;
  logic             r_cfg_vld;
  logic [1:0]       r_wave_sel;
  logic [1:0]       r_amp_sel;
  logic [31:0]      r_fword;

  // Up and down together cancel; saturated steps leave the index untouched.
  always_comb begin
    w_wave_nxt = r_wave + 2'(key_wave);
    w_amp_nxt  = r_amp + 2'(key_amp);
    w_idx_nxt  = r_idx;
    if (key_up && !key_dn && (r_idx < C_IDX_MAX)) begin
      w_idx_nxt = r_idx + IDX_W'(1);
    end else if (key_dn && !key_up && (r_idx > C_IDX_MIN)) begin
      w_idx_nxt = r_idx - IDX_W'(1);
    end
  end

  assign w_eff  = (w_wave_nxt != r_wave) || (w_amp_nxt != r_amp) || (w_idx_nxt != r_idx);
  assign w_prod = 32'(r_idx) * C_STEP;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wave <= 2'd0;
      r_amp  <= 2'd0;
      r_idx  <= C_IDX_INIT;
      r_chg  <= 1'b0;
    end else begin
      r_wave <= w_wave_nxt;
      r_amp  <= w_amp_nxt;
      r_idx  <= w_idx_nxt;
      r_chg  <= w_eff;
    end
  end

  // r_chg flags a change already visible in staging; pending only matters once a snapshot is out.
  assign w_any_pend = r_pend || r_chg;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_chg) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_pend_nxt = w_any_pend;
        if (cfg.cfg_rdy) begin
          w_state_nxt = w_any_pend ? S_CALC : S_IDLE;
          w_pend_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cfg_vld  <= 1'b0;
      r_wave_sel <= 2'd0;
      r_amp_sel  <= 2'd0;
      r_fword    <= C_FW_INIT;
    end else begin
      r_cfg_vld <= (w_state_nxt == S_SEND);
      if (r_state == S_CALC) begin
        r_wave_sel <= r_wave;
        r_amp_sel  <= r_amp;
        r_fword    <= w_prod;
      end
    end
  end

  assign cfg.cfg_vld  = r_cfg_vld;
  assign cfg.wave_sel = r_wave_sel;
  assign cfg.amp_sel  = r_amp_sel;
  assign cfg.fword    = r_fword;

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed bench for dds_key_ctrl: frequency stepping, saturation, backpressure, key cancellation, reset.
module tb_dds_key_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic key_wave, key_up, key_dn, key_amp;
  int   n_cmp = 0;
  int   n_err = 0;

  dds_key_ctrl_if cfg_if ();

  dds_key_ctrl #(
    .FW_STEP  (85899),
    .FREQ_MIN (1),
    .FREQ_MAX (100),
    .FREQ_INIT(1)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .key_wave(key_wave),
    .key_up  (key_up),
    .key_dn  (key_dn),
    .key_amp (key_amp),
    .cfg     (cfg_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic w, input logic u, input logic d, input logic a);
    key_wave = w;
    key_up   = u;
    key_dn   = d;
    key_amp  = a;
    tick();
    key_wave = 1'b0;
    key_up   = 1'b0;
    key_dn   = 1'b0;
    key_amp  = 1'b0;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    cfg_if.cfg_rdy = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (cfg_if.cfg_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %0b want 0", cfg_if.cfg_vld); end
    n_cmp++;
    if (cfg_if.fword !== 32'd85899) begin n_err++; $display("FAIL reset_fword got %0d want 85899", cfg_if.fword); end
    n_cmp++;
    if (cfg_if.wave_sel !== 2'd0) begin n_err++; $display("FAIL reset_wave got %0d want 0", cfg_if.wave_sel); end
    n_cmp++;
    if (cfg_if.amp_sel !== 2'd0) begin n_err++; $display("FAIL reset_amp got %0d want 0", cfg_if.amp_sel); end
    rstn = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (cfg_if.cfg_vld !== 1'b0) begin n_err++; $display("FAIL reset_idle_vld got %0b want 0", cfg_if.cfg_vld); end
  endtask

  task automatic test_freq_steps;
    logic [31:0] exp_fw;
    cfg_if.cfg_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_fw = 32'((k + 2) * 85899);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 9; c++) begin
        n_cmp++;
        if (cfg_if.cfg_vld !== (c == 2)) begin
          n_err++; $display("FAIL step%0d_vld_c%0d got %0b want %0b", k, c, cfg_if.cfg_vld, (c == 2));
        end
        if (c == 2) begin
          n_cmp++;
          if (cfg_if.fword !== exp_fw) begin
            n_err++; $display("FAIL step%0d_fword got %0d want %0d", k, cfg_if.fword, exp_fw);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_saturation;
    do_reset();
    cfg_if.cfg_rdy = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (cfg_if.cfg_vld !== 1'b0) begin n_err++; $display("FAIL dn_at_min_vld_c%0d got %0b want 0", c, cfg_if.cfg_vld); end
      tick();
    end
    n_cmp++;
    if (cfg_if.fword !== 32'd85899) begin n_err++; $display("FAIL dn_at_min_fword got %0d want 85899", cfg_if.fword); end
    repeat (100) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    n_cmp++;
    if (cfg_if.cfg_vld !== 1'b0) begin n_err++; $display("FAIL up100_vld got %0b want 0", cfg_if.cfg_vld); end
    n_cmp++;
    if (cfg_if.fword !== 32'd8589900) begin n_err++; $display("FAIL up100_fword got %0d want 8589900", cfg_if.fword); end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (cfg_if.cfg_vld !== 1'b0) begin n_err++; $display("FAIL up_at_max_vld_c%0d got %0b want 0", c, cfg_if.cfg_vld); end
      tick();
    end
    n_cmp++;
    if (cfg_if.fword !== 32'd8589900) begin n_err++; $display("FAIL up_at_max_fword got %0d want 8589900", cfg_if.fword); end
  endtask

  task automatic test_backpressure;
    cfg_if.cfg_rdy = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (cfg_if.cfg_vld !== 1'b1) begin n_err++; $display("FAIL bp_first_vld got %0b want 1", cfg_if.cfg_vld); end
    n_cmp++;
    if (cfg_if.fword !== 32'd8504001) begin n_err++; $display("FAIL bp_first_fword got %0d want 8504001", cfg_if.fword); end
    for (int i = 0; i < 20; i++) begin
      step((i == 2) || (i == 5) || (i == 8) || (i == 11), 1'b0, 1'b0, (i == 14));
      n_cmp++;
      if ({cfg_if.cfg_vld, cfg_if.wave_sel, cfg_if.amp_sel, cfg_if.fword} !== {1'b1, 2'd0, 2'd0, 32'd8504001}) begin
        n_err++;
        $display("FAIL bp_hold_%0d got vld=%0b wave=%0d amp=%0d fword=%0d want vld=1 wave=0 amp=0 fword=8504001",
                 i, cfg_if.cfg_vld, cfg_if.wave_sel, cfg_if.amp_sel, cfg_if.fword);
      end
    end
    cfg_if.cfg_rdy = 1'b1;
    tick();
    n_cmp++;
    if (cfg_if.cfg_vld !== 1'b0) begin n_err++; $display("FAIL bp_accept_vld got %0b want 0", cfg_if.cfg_vld); end
    tick();
    n_cmp++;
    if (cfg_if.cfg_vld !== 1'b1) begin n_err++; $display("FAIL bp_reissue_vld got %0b want 1", cfg_if.cfg_vld); end
    n_cmp++;
    if (cfg_if.wave_sel !== 2'd0) begin n_err++; $display("FAIL bp_reissue_wave got %0d want 0", cfg_if.wave_sel); end
    n_cmp++;
    if (cfg_if.amp_sel !== 2'd1) begin n_err++; $display("FAIL bp_reissue_amp got %0d want 1", cfg_if.amp_sel); end
    n_cmp++;
    if (cfg_if.fword !== 32'd8504001) begin n_err++; $display("FAIL bp_reissue_fword got %0d want 8504001", cfg_if.fword); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (cfg_if.cfg_vld !== 1'b0) begin n_err++; $display("FAIL bp_after_vld_c%0d got %0b want 0", c, cfg_if.cfg_vld); end
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    cfg_if.cfg_rdy = 1'b1;
    repeat (4) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (6) tick();
    end
    n_cmp++;
    if (cfg_if.fword !== 32'd429495) begin n_err++; $display("FAIL idx5_fword got %0d want 429495", cfg_if.fword); end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (cfg_if.cfg_vld !== 1'b0) begin n_err++; $display("FAIL updn_vld_c%0d got %0b want 0", c, cfg_if.cfg_vld); end
      tick();
    end
    n_cmp++;
    if (cfg_if.fword !== 32'd429495) begin n_err++; $display("FAIL updn_fword got %0d want 429495", cfg_if.fword); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      n_cmp++;
      if (cfg_if.cfg_vld !== (c == 2)) begin
        n_err++; $display("FAIL upwave_vld_c%0d got %0b want %0b", c, cfg_if.cfg_vld, (c == 2));
      end
      if (c == 2) begin
        n_cmp++;
        if (cfg_if.fword !== 32'd515394) begin n_err++; $display("FAIL upwave_fword got %0d want 515394", cfg_if.fword); end
        n_cmp++;
        if (cfg_if.wave_sel !== 2'd1) begin n_err++; $display("FAIL upwave_wave got %0d want 1", cfg_if.wave_sel); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    cfg_if.cfg_rdy = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (cfg_if.cfg_vld !== 1'b1) begin n_err++; $display("FAIL mid_send_vld got %0b want 1", cfg_if.cfg_vld); end
    n_cmp++;
    if (cfg_if.fword !== 32'd601293) begin n_err++; $display("FAIL mid_send_fword got %0d want 601293", cfg_if.fword); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({cfg_if.cfg_vld, cfg_if.wave_sel, cfg_if.amp_sel, cfg_if.fword} !== {1'b0, 2'd0, 2'd0, 32'd85899}) begin
      n_err++;
      $display("FAIL mid_reset got vld=%0b wave=%0d amp=%0d fword=%0d want vld=0 wave=0 amp=0 fword=85899",
               cfg_if.cfg_vld, cfg_if.wave_sel, cfg_if.amp_sel, cfg_if.fword);
    end
    tick();
    tick();
    rstn = 1'b1;
    cfg_if.cfg_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (cfg_if.cfg_vld !== 1'b0) begin n_err++; $display("FAIL post_reset_vld_c%0d got %0b want 0", c, cfg_if.cfg_vld); end
    end
    n_cmp++;
    if (cfg_if.fword !== 32'd85899) begin n_err++; $display("FAIL post_reset_fword got %0d want 85899", cfg_if.fword); end
  endtask

  initial begin
    rstn           = 1'b0;
    key_wave       = 1'b0;
    key_up         = 1'b0;
    key_dn         = 1'b0;
    key_amp        = 1'b0;
    cfg_if.cfg_rdy = 1'b0;
    test_reset();
    test_freq_steps();
    test_saturation();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
